// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the encrypt and decrypt datapaths.
// State and key words are column-major with byte 0 in bits [127:120].
package aes_pkg;

    localparam int Nb        = 4;
    localparam int KeyRounds = 10;
    localparam int KeyBusW   = 128 * (KeyRounds + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } dec_state_t;

    // Row-major 16x16 tables; entry b sits at bits [2047-8*b -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r of the state rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < Nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + Nb) % Nb) + r) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            res[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0]   a, b, c, d;
        res = '0;
        for (int col = 0; col < Nb; col++) begin
            a = s[127 - 32 * col -: 8];
            b = s[119 - 32 * col -: 8];
            c = s[111 - 32 * col -: 8];
            d = s[103 - 32 * col -: 8];
            res[127 - 32 * col -: 8] = gf_mul14(a) ^ gf_mul11(b) ^ gf_mul13(c) ^ gf_mul9(d);
            res[119 - 32 * col -: 8] = gf_mul9(a)  ^ gf_mul14(b) ^ gf_mul11(c) ^ gf_mul13(d);
            res[111 - 32 * col -: 8] = gf_mul13(a) ^ gf_mul9(b)  ^ gf_mul14(c) ^ gf_mul11(d);
            res[103 - 32 * col -: 8] = gf_mul11(a) ^ gf_mul13(b) ^ gf_mul9(c)  ^ gf_mul14(d);
        end
        return res;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int i);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 1; k < i; k++) begin
            rc = xtime(rc);
        end
        return rc;
    endfunction

    // Full AES-128 schedule; rk[0] occupies the top 128 bits of the bus.
    function automatic logic [KeyBusW-1:0] key_expand(input logic [127:0] key);
        logic [31:0]        w [4 * (KeyRounds + 1)];
        logic [31:0]        t;
        logic [KeyBusW-1:0] bus;
        for (int i = 0; i < 4; i++) begin
            w[i] = key[127 - 32 * i -: 32];
        end
        for (int i = 4; i < 4 * (KeyRounds + 1); i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / 4), 24'h0};
            end
            w[i] = w[i - 4] ^ t;
        end
        bus = '0;
        for (int i = 0; i < 4 * (KeyRounds + 1); i++) begin
            bus[KeyBusW - 1 - 32 * i -: 32] = w[i];
        end
        return bus;
    endfunction

    function automatic logic [127:0] last_round_key(input logic [127:0] key);
        logic [KeyBusW-1:0] bus;
        bus = key_expand(key);
        return bus[127:0];
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_round.sv
// One combinational AES inverse round; 'last' skips InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] keyed;

    assign keyed     = inv_sub_bytes(inv_shift_rows(state_in)) ^ round_key;
    assign state_out = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock with valid/ready on both sides.
// The initial AddRoundKey uses the live key so the result appears Nr cycles after acceptance.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int Width = 128,
    parameter int Nk    = 4,
    parameter int Nr    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in,
    input  logic [Width-1:0] Key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out,
    output logic             busy
);

    localparam int RW = $clog2(Nr);

    dec_state_t          fsm, fsm_next;
    logic [127:0]        state_reg;
    logic [32*Nk-1:0]    key_reg;
    logic [RW-1:0]       round;
    logic [127:0]        out_reg;
    logic [KeyBusW-1:0]  key_bus;
    logic [127:0]        rk_table [Nr+1];
    logic [127:0]        round_key;
    logic [127:0]        initial_key;
    logic [127:0]        round_out;
    logic                last;

    assign key_bus     = key_expand(key_reg);
    assign initial_key = last_round_key(Key);
    assign last        = (round == '0);

    always_comb begin
        for (int i = 0; i <= Nr; i++) begin
            rk_table[i] = key_bus[128 * (Nr + 1) - 1 - 128 * i -: 128];
        end
    end

    assign round_key = rk_table[round];

    aes_inv_round u_round (
        .state_in  (state_reg),
        .round_key (round_key),
        .last      (last),
        .state_out (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    fsm_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (last) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // out_reg is only written by the final round, so it holds through DONE and beyond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
            key_reg   <= '0;
            round     <= '0;
            out_reg   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        key_reg   <= Key;
                        state_reg <= in ^ initial_key;
                        round     <= RW'(Nr - 1);
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    if (last) begin
                        out_reg <= round_out;
                    end else begin
                        round <= round - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out = out_reg;

endmodule
